// File: rtl/mem_pkg.sv
// Shared types and sizing constants for the memory arbiter.
package mem_pkg;

    // Words per cache block (16-byte block of 16-bit words)
    localparam int BLOCK_WORDS = 8;
    // Byte-offset bits inside a block
    localparam int BLK_OFF_W   = 4;
    // Word-offset bits inside a block
    localparam int WORD_OFF_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE      = 2'd1,
        ST_FILL_ISSUE = 2'd2,
        ST_FILL_WAIT  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between the D-cache and I-cache fill requests.
// Index 0 is the D-cache, index 1 is the I-cache. On a tie the requester
// that was not served last wins; the pointer moves only when a grant is
// actually taken (i_en high).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    logic r_last_1;

    // Pick a winner; a lone request always wins, a tie goes against r_last_1
    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                o_gnt = r_last_1 ? 2'b01 : 2'b10;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    // Remember who was served last; reset says the I-cache was, so D wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_1 <= 1'b1;
        end else if (o_gnt[1]) begin
            r_last_1 <= 1'b1;
        end else if (o_gnt[0]) begin
            r_last_1 <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter for a write-through D-cache and two block-fill requesters.
//
// state         | meaning
// --------------+-------------------------------------------------------------
// ST_IDLE       | no memory command; the only state that samples requests
// ST_WRITE      | one-cycle write-through of the latched D-cache write
// ST_FILL_ISSUE | issuing the 8 word reads of a block, one per cycle
// ST_FILL_WAIT  | all reads issued, collecting the remaining read returns
module mem_arbiter #(
    parameter int AWIDTH      = 16,
    parameter int DWIDTH      = 16,
    parameter int BLOCK_WORDS = mem_pkg::BLOCK_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_wr_req,
    input  logic [AWIDTH-1:0] d_wr_addr,
    input  logic [DWIDTH-1:0] d_wr_data,
    input  logic              d_miss_req,
    input  logic [AWIDTH-1:0] d_miss_addr,
    input  logic              i_miss_req,
    input  logic [AWIDTH-1:0] i_miss_addr,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [DWIDTH-1:0] fill_data,
    output logic [2:0]        fill_word,
    output logic              d_fill_valid,
    output logic              i_fill_valid,
    output logic              d_fill_done,
    output logic              i_fill_done,
    output logic              d_wr_ack
);
    import mem_pkg::*;

    localparam logic [WORD_OFF_W-1:0] LAST_WORD = WORD_OFF_W'(BLOCK_WORDS - 1);

    state_t                  r_state;
    logic [AWIDTH-1:0]       r_addr;
    logic [DWIDTH-1:0]       r_wdata;
    logic [WORD_OFF_W-1:0]   r_issue_cnt;
    logic [WORD_OFF_W-1:0]   r_rx_cnt;
    logic                    r_gnt_i;

    logic [1:0]              w_gnt;
    logic                    w_arb_en;
    logic                    w_filling;
    logic                    w_rx;
    logic                    w_rx_last;

    // Writes outrank fills, so the fill pointer only advances when no write is pending
    assign w_arb_en  = (r_state == ST_IDLE) && !d_wr_req;
    assign w_filling = (r_state == ST_FILL_ISSUE) || (r_state == ST_FILL_WAIT);
    assign w_rx      = w_filling && mem_rvalid;
    assign w_rx_last = w_rx && (r_rx_cnt == LAST_WORD);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .i_req ({i_miss_req, d_miss_req}),
        .i_en  (w_arb_en),
        .o_gnt (w_gnt)
    );

    // Sequencing: grant from IDLE, count issued and returned words, finish on the 8th return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_issue_cnt <= '0;
            r_rx_cnt    <= '0;
            r_gnt_i     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_issue_cnt <= '0;
                    r_rx_cnt    <= '0;
                    if (d_wr_req) begin
                        r_state <= ST_WRITE;
                        r_addr  <= d_wr_addr;
                        r_wdata <= d_wr_data;
                    end else if (w_gnt[0]) begin
                        r_state <= ST_FILL_ISSUE;
                        r_addr  <= d_miss_addr;
                        r_gnt_i <= 1'b0;
                    end else if (w_gnt[1]) begin
                        r_state <= ST_FILL_ISSUE;
                        r_addr  <= i_miss_addr;
                        r_gnt_i <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                end
                ST_FILL_ISSUE, ST_FILL_WAIT: begin
                    if (r_state == ST_FILL_ISSUE) begin
                        if (r_issue_cnt == LAST_WORD) begin
                            r_issue_cnt <= '0;
                            r_state     <= ST_FILL_WAIT;
                        end else begin
                            r_issue_cnt <= r_issue_cnt + 3'd1;
                        end
                    end
                    // A zero-latency memory could finish while still issuing; the return wins
                    if (w_rx) begin
                        if (w_rx_last) begin
                            r_rx_cnt    <= '0;
                            r_issue_cnt <= '0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory command and fill return outputs; everything is zero unless commanding or returning
    always_comb begin
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        d_wr_ack     = 1'b0;
        fill_data    = '0;
        fill_word    = '0;
        d_fill_valid = 1'b0;
        i_fill_valid = 1'b0;
        d_fill_done  = 1'b0;
        i_fill_done  = 1'b0;

        if (r_state == ST_WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
            d_wr_ack  = 1'b1;
        end else if (r_state == ST_FILL_ISSUE) begin
            mem_en   = 1'b1;
            mem_addr = {r_addr[AWIDTH-1:BLK_OFF_W], r_issue_cnt, 1'b0};
        end

        // Read returns pass straight through to whichever cache owns the fill
        if (w_rx) begin
            fill_data    = mem_rdata;
            fill_word    = r_rx_cnt;
            d_fill_valid = !r_gnt_i;
            i_fill_valid = r_gnt_i;
            d_fill_done  = w_rx_last && !r_gnt_i;
            i_fill_done  = w_rx_last && r_gnt_i;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model
// and a fixed-latency (4 cycle) pipelined memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_wr_req;
    logic [15:0] d_wr_addr;
    logic [15:0] d_wr_data;
    logic        d_miss_req;
    logic [15:0] d_miss_addr;
    logic        i_miss_req;
    logic [15:0] i_miss_addr;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        d_fill_valid;
    logic        i_fill_valid;
    logic        d_fill_done;
    logic        i_fill_done;
    logic        d_wr_ack;

    mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .d_wr_req    (d_wr_req),
        .d_wr_addr   (d_wr_addr),
        .d_wr_data   (d_wr_data),
        .d_miss_req  (d_miss_req),
        .d_miss_addr (d_miss_addr),
        .i_miss_req  (i_miss_req),
        .i_miss_addr (i_miss_addr),
        .mem_en      (mem_en),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .fill_data   (fill_data),
        .fill_word   (fill_word),
        .d_fill_valid(d_fill_valid),
        .i_fill_valid(i_fill_valid),
        .d_fill_done (d_fill_done),
        .i_fill_done (i_fill_done),
        .d_wr_ack    (d_wr_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory pipeline (latency 4)
    logic        pv [4];
    logic [15:0] pd [4];

    // reference model: 0 idle, 1 write, 2 D fill, 3 I fill
    int          cyc = 0;
    int          m_kind = 0;
    logic [15:0] m_addr = 16'h0;
    logic [15:0] m_data = 16'h0;
    int          m_issued = 0;
    int          m_rcvd = 0;
    logic        m_last_i = 1'b1;
    logic [63:0] glog = 64'h0;
    int          gstart [4];
    int          gidx = 0;

    // observation counters
    int n_dv, n_iv, n_dd, n_id, n_ack;
    logic c_dd, c_id, c_en;
    logic auto_d, auto_i, auto_w;
    logic [15:0] addr_q [$];
    int first_en_cyc, dd_cyc;
    logic [2:0] cap_fw_done;
    logic [32:0] cap_wr;

    function automatic logic [15:0] rd_of(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic log_grant(input logic [7:0] ch);
        glog = {glog[55:0], ch};
        if (gidx < 4) gstart[gidx] = cyc + 1;
        gidx++;
    endtask

    task automatic model_step();
        logic [33:0] e_cmd;
        logic [15:0] base;
        logic        e_v, e_done, e_ack;
        logic [15:0] e_fd;
        logic [2:0]  e_fw;
        cyc++;
        if (rst) begin
            chk("reset_outputs", 64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
                                      d_fill_valid, i_fill_valid, d_fill_done, i_fill_done, d_wr_ack}), 64'h0);
            m_kind   = 0;
            m_last_i = 1'b1;
            return;
        end
        e_cmd = '0; e_v = 1'b0; e_done = 1'b0; e_ack = 1'b0; e_fd = '0; e_fw = '0;
        base  = m_addr & 16'hFFF0;
        if (m_kind == 1) begin
            e_cmd = {1'b1, 1'b1, m_addr, m_data};
            e_ack = 1'b1;
        end else if (m_kind >= 2) begin
            if (m_issued < 8) e_cmd = {1'b1, 1'b0, base + 16'(2 * m_issued), 16'h0};
            if (mem_rvalid) begin
                e_v    = 1'b1;
                e_fd   = rd_of(base + 16'(2 * m_rcvd));
                e_fw   = 3'(m_rcvd);
                e_done = (m_rcvd == 7);
            end
        end
        chk("mem_cmd", 64'({mem_en, mem_wr, mem_addr, mem_wdata}), 64'(e_cmd));
        chk("strobes", 64'({d_wr_ack, d_fill_valid, i_fill_valid, d_fill_done, i_fill_done}),
            64'({e_ack, e_v && m_kind == 2, e_v && m_kind == 3, e_done && m_kind == 2, e_done && m_kind == 3}));
        chk("fill_data", 64'(fill_data), 64'(e_fd));
        if (e_v) chk("fill_word", 64'(fill_word), 64'(e_fw));

        // advance to the next cycle
        if (m_kind == 0) begin
            if (d_wr_req) begin
                m_kind = 1; m_addr = d_wr_addr; m_data = d_wr_data;
                log_grant(8'h57);
            end else if (d_miss_req || i_miss_req) begin
                if (d_miss_req && (!i_miss_req || m_last_i)) begin
                    m_kind = 2; m_addr = d_miss_addr; m_last_i = 1'b0;
                    log_grant(8'h44);
                end else begin
                    m_kind = 3; m_addr = i_miss_addr; m_last_i = 1'b1;
                    log_grant(8'h49);
                end
                m_issued = 0;
                m_rcvd   = 0;
            end
        end else if (m_kind == 1) begin
            m_kind = 0;
        end else begin
            if (m_issued < 8) m_issued++;
            if (mem_rvalid) begin
                m_rcvd++;
                if (m_rcvd == 8) m_kind = 0;
            end
        end
    endtask

    // one clock: model compare and observation at negedge, memory/requesters just after posedge
    task automatic tick();
        @(negedge clk);
        model_step();
        c_dd = d_fill_done;
        c_id = i_fill_done;
        c_en = mem_en;
        if (d_fill_valid) n_dv++;
        if (i_fill_valid) n_iv++;
        if (d_fill_done) begin n_dd++; dd_cyc = cyc; cap_fw_done = fill_word; end
        if (i_fill_done) n_id++;
        if (d_wr_ack) begin n_ack++; cap_wr = {mem_wr, mem_addr, mem_wdata}; end
        if (mem_en && !mem_wr) begin
            if (addr_q.size() == 0) first_en_cyc = cyc;
            addr_q.push_back(mem_addr);
        end
        for (int i = 3; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = mem_en && !mem_wr;
        pd[0] = rd_of(mem_addr);
        @(posedge clk);
        #1;
        mem_rvalid = pv[3];
        mem_rdata  = pv[3] ? pd[3] : 16'h0;
        if (auto_d && c_dd) d_miss_req = 1'b0;
        if (auto_i && c_id) i_miss_req = 1'b0;
        if (auto_w && d_wr_ack === 1'b0 && n_ack > 0) d_wr_req = 1'b0;
    endtask

    task automatic clear_obs();
        n_dv = 0; n_iv = 0; n_dd = 0; n_id = 0; n_ack = 0;
        addr_q.delete();
        first_en_cyc = 0; dd_cyc = 0; cap_fw_done = '0; cap_wr = '0;
    endtask

    initial begin
        rst = 1'b1;
        d_wr_req = 1'b0; d_wr_addr = '0; d_wr_data = '0;
        d_miss_req = 1'b0; d_miss_addr = '0;
        i_miss_req = 1'b0; i_miss_addr = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        auto_d = 1'b0; auto_i = 1'b0; auto_w = 1'b0;
        for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pd[i] = '0; gstart[i] = 0; end
        clear_obs();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // write, D fill and I fill requested together
        clear_obs(); glog = '0; gidx = 0;
        auto_w = 1'b1; auto_d = 1'b1; auto_i = 1'b1;
        d_wr_addr = 16'h0010; d_wr_data = 16'h1234; d_wr_req = 1'b1;
        d_miss_addr = 16'h0123; d_miss_req = 1'b1;
        i_miss_addr = 16'h0458; i_miss_req = 1'b1;
        for (int i = 0; i < 80 && n_id == 0; i++) tick();
        chk("prio_i_done_seen", 64'(n_id), 64'd1);
        chk("grant_order_wdi", glog, 64'h574449);
        chk("gap_write_to_d", 64'(gstart[1] - gstart[0]), 64'd2);
        chk("gap_d_to_i", 64'(gstart[2] - gstart[1]), 64'd13);
        chk("prio_d_done_count", 64'(n_dd), 64'd1);
        auto_w = 1'b0;

        // both misses held continuously: grants must alternate
        clear_obs(); glog = '0; gidx = 0;
        auto_d = 1'b0; auto_i = 1'b0;
        d_miss_addr = 16'h0A00; i_miss_addr = 16'h0B16;
        d_miss_req = 1'b1; i_miss_req = 1'b1;
        for (int i = 0; i < 120 && (n_dd + n_id) < 4; i++) tick();
        d_miss_req = 1'b0; i_miss_req = 1'b0;
        repeat (2) tick();
        chk("rr_order_didi", glog, 64'h44494449);
        chk("rr_d_done_count", 64'(n_dd), 64'd2);
        chk("rr_i_done_count", 64'(n_id), 64'd2);

        // single D miss at 0x0123
        clear_obs(); auto_d = 1'b1;
        d_miss_addr = 16'h0123; d_miss_req = 1'b1;
        for (int i = 0; i < 40 && n_dd == 0; i++) tick();
        tick();
        chk("dfill_issue_count", 64'(addr_q.size()), 64'd8);
        chk("dfill_addr0", 64'(addr_q[0]), 64'h0120);
        chk("dfill_addr1", 64'(addr_q[1]), 64'h0122);
        chk("dfill_addr7", 64'(addr_q[7]), 64'h012E);
        chk("dfill_valid_count", 64'(n_dv), 64'd8);
        chk("dfill_done_count", 64'(n_dd), 64'd1);
        chk("dfill_done_word", 64'(cap_fw_done), 64'd7);
        chk("dfill_done_latency", 64'(dd_cyc - first_en_cyc), 64'd11);

        // single write-through
        clear_obs(); auto_w = 1'b1;
        d_wr_addr = 16'h0100; d_wr_data = 16'hFF00; d_wr_req = 1'b1;
        for (int i = 0; i < 10 && n_ack == 0; i++) tick();
        chk("write_cmd", 64'(cap_wr), 64'({1'b1, 16'h0100, 16'hFF00}));
        chk("idle_after_write", 64'({mem_en, d_wr_ack}), 64'h0);
        tick();
        chk("write_ack_count", 64'(n_ack), 64'd1);
        auto_w = 1'b0;

        // reset after the third returned word of an I fill
        clear_obs(); auto_i = 1'b1;
        i_miss_addr = 16'h0346; i_miss_req = 1'b1;
        for (int i = 0; i < 20 && n_iv < 3; i++) tick();
        chk("pre_reset_valids", 64'(n_iv), 64'd3);
        i_miss_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("reset_mid_fill", 64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
                                   d_fill_valid, i_fill_valid, d_fill_done, i_fill_done, d_wr_ack}), 64'h0);
        m_kind = 0;
        clear_obs();
        repeat (2) tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("no_valid_after_reset", 64'(n_dv + n_iv), 64'd0);
        chk("no_done_after_reset", 64'(n_dd + n_id), 64'd0);
        clear_obs(); auto_d = 1'b1;
        d_miss_addr = 16'h0200; d_miss_req = 1'b1;
        for (int i = 0; i < 40 && n_dd == 0; i++) tick();
        chk("post_reset_addr0", 64'(addr_q[0]), 64'h0200);
        chk("post_reset_valids", 64'(n_dv), 64'd8);

        // I request dropped right after grant
        clear_obs();
        i_miss_addr = 16'h04A2; i_miss_req = 1'b1;
        for (int i = 0; i < 10 && !c_en; i++) tick();
        i_miss_req = 1'b0;
        for (int i = 0; i < 30 && n_id == 0; i++) tick();
        chk("drop_i_issue_count", 64'(addr_q.size()), 64'd8);
        chk("drop_i_valids", 64'(n_iv), 64'd8);
        chk("drop_i_done", 64'(n_id), 64'd1);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
